// File: rtl/core_pipe_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : core_pipe_fetch_pkg
// Brief    : Shared fetch constants and the instruction buffer entry type.
// Revision : 1.0 - initial release
// ============================================================================
package core_pipe_fetch_pkg;

    localparam logic [63:0] C_RESET_PC = 64'h0000_0000_8000_0000;
    localparam int unsigned C_XLEN     = 64;
    localparam int unsigned C_INSTR_W  = 32;

    typedef struct packed {
        logic [C_XLEN-1:0]    pc;
        logic [C_INSTR_W-1:0] instr;
        logic                 ferr;
    } fetch_entry_t;

    localparam int unsigned C_ENTRY_W = $bits(fetch_entry_t);

endpackage
`default_nettype wire

// File: rtl/core_pipe_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : core_pipe_fetch_buffer
// Brief    : Instruction FIFO with dual-entry push, single pop and flush.
// Revision : 1.0 - initial release
// ============================================================================
module core_pipe_fetch_buffer
    import core_pipe_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_flush,
    input  logic                   i_push0,
    input  fetch_entry_t           i_push0_data,
    input  logic                   i_push1,
    input  fetch_entry_t           i_push1_data,
    input  logic                   i_pop,
    output logic [$clog2(DEPTH):0] o_count,
    output fetch_entry_t           o_head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] w_wptr_p1;
    logic [CNT_W-1:0] r_count;
    logic [1:0]       w_n_push;

    assign w_wptr_p1 = r_wptr + 1'b1;
    assign w_n_push  = {1'b0, i_push0} + {1'b0, i_push1};

    // Storage needs no reset: the head is masked whenever the count is zero.
    always_ff @(posedge clk) begin
        if (!i_flush) begin
            if (i_push0) begin
                r_mem[r_wptr] <= i_push0_data;
            end
            if (i_push1) begin
                r_mem[w_wptr_p1] <= i_push1_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= r_wptr + PTR_W'(w_n_push);
            r_rptr  <= r_rptr + PTR_W'(i_pop);
            r_count <= r_count + CNT_W'(w_n_push) - CNT_W'(i_pop);
        end
    end

    assign o_count = r_count;
    assign o_head  = (r_count != '0) ? r_mem[r_rptr] : '0;

endmodule
`default_nettype wire

// File: rtl/core_pipe_fetch.sv
`default_nettype none
// ============================================================================
// Module   : core_pipe_fetch
// Brief    : Fetch stage: 64-bit imem requests, 32-bit split, redirect handling.
// Revision : 1.0 - initial release
// ============================================================================
module core_pipe_fetch
    import core_pipe_fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC  = C_RESET_PC,
    parameter int unsigned BUF_DEPTH = 4
) (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        cf_valid,
    output logic        cf_ack,
    input  logic [63:0] cf_target,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_err,
    input  logic [63:0] imem_rdata,
    output logic        s1_valid,
    input  logic        s1_ready,
    output logic [63:0] s1_pc,
    output logic [31:0] s1_instr,
    output logic        s1_ferr
);

    localparam int unsigned       CNT_W     = $clog2(BUF_DEPTH) + 1;
    localparam logic [CNT_W-1:0]  C_REQ_MAX = CNT_W'(BUF_DEPTH - 2);

    logic [63:0]      r_fetch_pc;
    logic             r_halted;
    logic             r_live;
    logic [CNT_W-1:0] w_count;
    fetch_entry_t     w_head;
    fetch_entry_t     w_push0_data;
    fetch_entry_t     w_push1_data;
    logic             w_take;
    logic             w_ack;
    logic             w_push0;
    logic             w_push1;
    logic             w_pop;
    logic             w_unused_tgt;

    // Requiring room for two entries means a granted doubleword always fits.
    assign imem_req  = !g_reset && !r_halted && (w_count <= C_REQ_MAX);
    assign imem_addr = {r_fetch_pc[63:3], 3'b000};
    assign w_take    = imem_req && imem_gnt;

    // A redirect waits for any outstanding request so the bus never sees it dropped.
    assign w_ack  = cf_valid && r_live && !g_reset && (!imem_req || imem_gnt);
    assign cf_ack = w_ack;

    assign w_push0 = w_take && !w_ack;
    assign w_push1 = w_push0 && !imem_err && !r_fetch_pc[2];

    always_comb begin
        w_push0_data.pc    = r_fetch_pc;
        w_push0_data.instr = r_fetch_pc[2] ? imem_rdata[63:32] : imem_rdata[31:0];
        w_push0_data.ferr  = 1'b0;
        if (imem_err) begin
            w_push0_data.instr = '0;
            w_push0_data.ferr  = 1'b1;
        end
        w_push1_data.pc    = {r_fetch_pc[63:3], 1'b1, r_fetch_pc[1:0]};
        w_push1_data.instr = imem_rdata[63:32];
        w_push1_data.ferr  = 1'b0;
    end

    assign s1_valid = (w_count != '0) && !cf_valid;
    assign w_pop    = s1_valid && s1_ready;
    assign s1_pc    = w_head.pc;
    assign s1_instr = w_head.instr;
    assign s1_ferr  = w_head.ferr;

    assign w_unused_tgt = ^cf_target[1:0];

    core_pipe_fetch_buffer #(
        .DEPTH        (BUF_DEPTH)
    ) u_buffer (
        .clk          (g_clk),
        .rst          (g_reset),
        .i_flush      (w_ack),
        .i_push0      (w_push0),
        .i_push0_data (w_push0_data),
        .i_push1      (w_push1),
        .i_push1_data (w_push1_data),
        .i_pop        (w_pop),
        .o_count      (w_count),
        .o_head       (w_head)
    );

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_fetch_pc <= RESET_PC;
            r_halted   <= 1'b0;
            r_live     <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (w_ack) begin
                r_fetch_pc <= {cf_target[63:2], 2'b00};
                r_halted   <= 1'b0;
            end else if (w_take) begin
                if (imem_err) begin
                    r_halted <= 1'b1;
                end else begin
                    r_fetch_pc <= {r_fetch_pc[63:3] + 61'd1, 3'b000};
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_core_pipe_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_pipe_fetch
// Brief    : Self-checking bench for core_pipe_fetch with a scoreboard model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_pipe_fetch;

    localparam int          DEPTH  = 4;
    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        ferr;
    } exp_t;

    typedef struct {
        logic [63:0] tgt;
        int          stall;
        logic [63:0] addr;
        logic [63:0] pc;
        logic [63:0] pc2;
    } redir_vec_t;

    logic        g_clk;
    logic        g_reset;
    logic        cf_valid;
    logic        cf_ack;
    logic [63:0] cf_target;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt;
    logic        imem_err;
    logic [63:0] imem_rdata;
    logic        s1_valid;
    logic        s1_ready;
    logic [63:0] s1_pc;
    logic [31:0] s1_instr;
    logic        s1_ferr;

    core_pipe_fetch #(
        .RESET_PC   (RST_PC),
        .BUF_DEPTH  (DEPTH)
    ) dut (
        .g_clk      (g_clk),
        .g_reset    (g_reset),
        .cf_valid   (cf_valid),
        .cf_ack     (cf_ack),
        .cf_target  (cf_target),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_err   (imem_err),
        .imem_rdata (imem_rdata),
        .s1_valid   (s1_valid),
        .s1_ready   (s1_ready),
        .s1_pc      (s1_pc),
        .s1_instr   (s1_instr),
        .s1_ferr    (s1_ferr)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    exp_t        sb[$];
    exp_t        popped[$];
    logic [63:0] gnt_addrs[$];
    logic [63:0] exp_pc   = RST_PC;
    logic        halted   = 1'b0;
    logic        live     = 1'b0;
    logic [63:0] err_addr = 64'h1;
    logic        last_req, last_ack, last_sv, last_ferr;
    logic [63:0] last_addr, last_pc;
    logic [31:0] last_instr;
    redir_vec_t  vecs[4];

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [63:0] popped_pc(input int i);
        return (popped.size() > i) ? popped[i].pc : 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // One clock: inputs applied on the falling edge, outputs checked 1ns later,
    // then the model advances to what the next rising edge must produce.
    task automatic step(input logic rst, input logic cfv, input logic [63:0] tgt,
                        input logic rdy, input logic gen);
        logic [63:0] base;
        logic        erg, exp_req, exp_ack, exp_sv;
        exp_t        e;
        @(negedge g_clk);
        base       = {exp_pc[63:3], 3'b000};
        erg        = gen && (base == err_addr);
        g_reset    = rst;
        cf_valid   = cfv;
        cf_target  = tgt;
        s1_ready   = rdy;
        imem_gnt   = gen;
        imem_err   = erg;
        imem_rdata = {mem_word(base + 64'd4), mem_word(base)};
        #1;
        last_req = imem_req;   last_addr  = imem_addr; last_ack  = cf_ack;
        last_sv  = s1_valid;   last_pc    = s1_pc;     last_instr = s1_instr;
        last_ferr = s1_ferr;
        if (rst) begin
            chk("rst_imem_req", imem_req, 0);
            chk("rst_cf_ack", cf_ack, 0);
            chk("rst_s1_valid", s1_valid, 0);
            chk("rst_s1_pc", s1_pc, 0);
            chk("rst_s1_instr", s1_instr, 0);
            chk("rst_s1_ferr", s1_ferr, 0);
            sb.delete();
            exp_pc = RST_PC;
            halted = 1'b0;
            live   = 1'b0;
        end else begin
            exp_req = !halted && ((DEPTH - sb.size()) >= 2);
            exp_ack = live && cfv && (!exp_req || gen);
            exp_sv  = (sb.size() != 0) && !cfv;
            chk("imem_req", imem_req, exp_req);
            if (exp_req) chk("imem_addr", imem_addr, base);
            chk("cf_ack", cf_ack, exp_ack);
            chk("s1_valid", s1_valid, exp_sv);
            if (sb.size() != 0) begin
                chk("s1_pc", s1_pc, sb[0].pc);
                chk("s1_instr", s1_instr, sb[0].instr);
                chk("s1_ferr", s1_ferr, sb[0].ferr);
            end else begin
                chk("s1_pc_empty", s1_pc, 0);
                chk("s1_instr_empty", s1_instr, 0);
            end
            if (s1_valid && rdy) begin
                e.pc = s1_pc; e.instr = s1_instr; e.ferr = s1_ferr;
                popped.push_back(e);
            end
            if (imem_req && gen) gnt_addrs.push_back(imem_addr);
            if (exp_ack) begin
                sb.delete();
                exp_pc = {tgt[63:2], 2'b00};
                halted = 1'b0;
            end else begin
                if (exp_sv && rdy) void'(sb.pop_front());
                if (exp_req && gen) begin
                    if (erg) begin
                        e.pc = exp_pc; e.instr = 32'h0; e.ferr = 1'b1;
                        sb.push_back(e);
                        halted = 1'b1;
                    end else begin
                        if (!exp_pc[2]) begin
                            e.pc = exp_pc; e.instr = mem_word(base); e.ferr = 1'b0;
                            sb.push_back(e);
                            e.pc = exp_pc + 64'd4;
                        end else begin
                            e.pc = exp_pc;
                        end
                        e.instr = mem_word(base + 64'd4); e.ferr = 1'b0;
                        sb.push_back(e);
                        exp_pc = base + 64'd8;
                    end
                end
            end
            live = 1'b1;
        end
    endtask

    task automatic run(input int n, input logic rdy, input logic gen);
        repeat (n) step(1'b0, 1'b0, 64'h0, rdy, gen);
    endtask

    // Leaves a request raised and un-granted.
    task automatic wait_req();
        int k = 0;
        do begin
            step(1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
            k++;
        end while (!last_req && k < 20);
        chk("wait_req_bound", last_req, 1);
    endtask

    task automatic redirect(input logic [63:0] tgt, input int stall);
        wait_req();
        for (int i = 0; i < stall; i++) begin
            step(1'b0, 1'b1, tgt, 1'b1, 1'b0);
            chk("cf_ack_while_waiting", last_ack, 0);
            chk("s1_valid_masked_wait", last_sv, 0);
        end
        step(1'b0, 1'b1, tgt, 1'b1, 1'b1);
        chk("cf_ack_on_grant", last_ack, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int n_held, n_before, k;
        vecs[0] = '{64'h0000_0000_8000_0104, 3, 64'h0000_0000_8000_0100,
                    64'h0000_0000_8000_0104, 64'h0000_0000_8000_0108};
        vecs[1] = '{64'h0000_0000_8000_0203, 0, 64'h0000_0000_8000_0200,
                    64'h0000_0000_8000_0200, 64'h0000_0000_8000_0204};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFC, 2, 64'hFFFF_FFFF_FFFF_FFF8,
                    64'hFFFF_FFFF_FFFF_FFFC, 64'h0000_0000_0000_0000};
        vecs[3] = '{64'h0000_0001_2345_6788, 1, 64'h0000_0001_2345_6788,
                    64'h0000_0001_2345_6788, 64'h0000_0001_2345_678C};

        g_reset = 1'b1; cf_valid = 1'b0; cf_target = '0; s1_ready = 1'b0;
        imem_gnt = 1'b0; imem_err = 1'b0; imem_rdata = '0;

        // Reset with cf_valid high: ack must stay low.
        step(1'b1, 1'b1, 64'h1234, 1'b1, 1'b1);
        step(1'b1, 1'b1, 64'h1234, 1'b1, 1'b1);

        // Streaming from RESET_PC.
        popped.delete(); gnt_addrs.delete();
        step(1'b0, 1'b0, 64'h0, 1'b1, 1'b1);
        chk("req_first_cycle", last_req, 1);
        chk("addr_first_cycle", last_addr, RST_PC);
        run(7, 1'b1, 1'b1);
        chk("gnt_addr0", (gnt_addrs.size() > 0) ? gnt_addrs[0] : 64'h1, 64'h8000_0000);
        chk("gnt_addr1", (gnt_addrs.size() > 1) ? gnt_addrs[1] : 64'h1, 64'h8000_0008);
        chk("pop_pc0", popped_pc(0), 64'h8000_0000);
        chk("pop_pc1", popped_pc(1), 64'h8000_0004);
        chk("pop_pc2", popped_pc(2), 64'h8000_0008);
        chk("pop_instr1", (popped.size() > 1) ? popped[1].instr : 32'h0, mem_word(64'h8000_0004));

        // Back-pressure: buffer fills, requests stop, nothing is lost.
        run(6, 1'b0, 1'b1);
        chk("req_when_full", last_req, 0);
        chk("valid_when_full", last_sv, 1);
        n_held = sb.size();
        popped.delete();
        run(6, 1'b1, 1'b0);
        chk("drained_count", popped.size(), n_held);
        chk("drained_valid", last_sv, 0);

        // Bus error at 0x8000_0010 halts fetch until a redirect.
        redirect(64'h8000_0000, 0);
        err_addr = 64'h8000_0010;
        popped.delete();
        run(12, 1'b1, 1'b1);
        chk("err_pop_count", popped.size(), 5);
        chk("err_pc", popped_pc(4), 64'h8000_0010);
        chk("err_ferr", (popped.size() > 4) ? popped[4].ferr : 1'b0, 1);
        chk("err_instr", (popped.size() > 4) ? popped[4].instr : 32'hFFFF_FFFF, 0);
        chk("err_req_halted", last_req, 0);
        err_addr = 64'h1;
        step(1'b0, 1'b1, 64'h8000_0200, 1'b1, 1'b1);
        chk("err_redirect_ack", last_ack, 1);
        step(1'b0, 1'b0, 64'h0, 1'b1, 1'b1);
        chk("resume_req", last_req, 1);
        chk("resume_addr", last_addr, 64'h8000_0200);

        // Redirect while three entries are buffered and decode is ready.
        k = 0;
        while (sb.size() != 3 && k < 20) begin
            run(1, 1'b1, 1'b1);
            k++;
        end
        chk("reach_count3_bound", s1_valid, 1);
        n_before = popped.size();
        step(1'b0, 1'b1, 64'h8000_0300, 1'b1, 1'b1);
        chk("cf_masks_valid", last_sv, 0);
        chk("cf_no_pop", popped.size(), n_before);
        chk("cf_ack_count3", last_ack, 1);
        popped.delete();
        run(4, 1'b1, 1'b1);
        chk("cf_first_pc", popped_pc(0), 64'h8000_0300);

        // Table of redirect targets: request address and first instructions.
        foreach (vecs[i]) begin
            redirect(vecs[i].tgt, vecs[i].stall);
            step(1'b0, 1'b0, 64'h0, 1'b1, 1'b1);
            chk("vec_req", last_req, 1);
            chk("vec_addr", last_addr, vecs[i].addr);
            step(1'b0, 1'b0, 64'h0, 1'b1, 1'b1);
            chk("vec_valid", last_sv, 1);
            chk("vec_pc", last_pc, vecs[i].pc);
            chk("vec_instr", last_instr, mem_word(vecs[i].pc));
            step(1'b0, 1'b0, 64'h0, 1'b1, 1'b1);
            chk("vec_pc2", last_pc, vecs[i].pc2);
        end

        // Reset pulse mid-stream with a request outstanding.
        wait_req();
        step(1'b1, 1'b0, 64'h0, 1'b1, 1'b1);
        chk("req_dropped_in_reset", last_req, 0);
        step(1'b1, 1'b0, 64'h0, 1'b1, 1'b1);
        popped.delete();
        step(1'b0, 1'b0, 64'h0, 1'b1, 1'b1);
        chk("restart_req", last_req, 1);
        chk("restart_addr", last_addr, RST_PC);
        run(3, 1'b1, 1'b1);
        chk("restart_pc", popped_pc(0), RST_PC);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
